// File: rtl/regfile_pkg.sv
// Shared constants, typedefs and helpers for the register file with busy scoreboard.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_NUM_REGS = 8;
  localparam int unsigned DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  // NUM_REGS need not be a power of two, so the top of the address space can be unused.
  function automatic logic addr_valid(input logic [31:0] addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination busy, write-back clears it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic                i_issue_en,
  input  logic [ADDR_W-1:0]   i_issue_addr,
  output logic                o_issue_ok,
  output logic [NUM_REGS-1:0] o_busy_vec,
  output logic [ADDR_W:0]     o_busy_cnt
);

  localparam logic [ADDR_W:0] CntOne = (ADDR_W + 1)'(1);

  logic [NUM_REGS-1:0] r_busy_vec;
  logic [ADDR_W:0]     r_busy_cnt;

  logic                w_wr_hit;
  logic                w_iss_valid;
  logic                w_iss_zero;
  logic                w_busy_at_iss;
  logic                w_busy_at_wr;
  logic                w_set;
  logic                w_set_new;
  logic                w_clr_hit;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [ADDR_W:0]     w_cnt_nxt;

  always_comb begin
    w_busy_at_iss = 1'b0;
    w_busy_at_wr  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_issue_addr == ADDR_W'(i)) w_busy_at_iss = r_busy_vec[i];
      if (i_wr_addr == ADDR_W'(i))    w_busy_at_wr  = r_busy_vec[i];
    end
  end

  assign w_iss_zero  = ZERO_REG && (i_issue_addr == '0);
  assign w_iss_valid = addr_valid(32'(i_issue_addr), NUM_REGS);
  assign w_wr_hit    = i_wr_en && addr_valid(32'(i_wr_addr), NUM_REGS) &&
                       !(ZERO_REG && (i_wr_addr == '0));

  // A same-cycle write-back to the target frees it in time for the new issue.
  assign o_issue_ok = i_issue_en && w_iss_valid &&
                      (!w_busy_at_iss || (i_wr_en && (i_wr_addr == i_issue_addr)));
  assign w_set      = o_issue_ok && !w_iss_zero;

  // Count deltas: a clear that is overridden by an issue to the same register is no change.
  assign w_set_new = w_set && !w_busy_at_iss;
  assign w_clr_hit = w_wr_hit && w_busy_at_wr && !(w_set && (i_wr_addr == i_issue_addr));

  always_comb begin
    w_busy_nxt = r_busy_vec;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_wr_hit && (i_wr_addr == ADDR_W'(i)))    w_busy_nxt[i] = 1'b0;
      if (w_set    && (i_issue_addr == ADDR_W'(i))) w_busy_nxt[i] = 1'b1;
    end
    w_cnt_nxt = r_busy_cnt;
    case ({w_set_new, w_clr_hit})
      2'b10:   w_cnt_nxt = r_busy_cnt + CntOne;
      2'b01:   w_cnt_nxt = r_busy_cnt - CntOne;
      default: w_cnt_nxt = r_busy_cnt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_busy_vec <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy_vec <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign o_busy_vec = r_busy_vec;
  assign o_busy_cnt = r_busy_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Register file with N combinational read ports, one write port, optional write-to-read
// bypass, optional hardwired-zero r0 and a busy scoreboard for issue/write-back tracking.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  output logic [NUM_RD-1:0]          o_rd_busy,
  input  logic                       i_issue_en,
  input  logic [ADDR_W-1:0]          i_issue_addr,
  output logic                       o_issue_ok,
  output logic [NUM_REGS-1:0]        o_busy_vec,
  output logic [ADDR_W:0]            o_busy_cnt
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  logic                      w_wr_hit;
  logic [NUM_REGS-1:0]       w_busy_vec;
  logic [NUM_RD*DATA_W-1:0]  w_rd_data;
  logic [NUM_RD-1:0]         w_rd_busy;
  logic [ADDR_W-1:0]         w_ra;

  assign w_wr_hit = i_wr_en && addr_valid(32'(i_wr_addr), NUM_REGS) &&
                    !(ZERO_REG && (i_wr_addr == '0));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_hit && (i_wr_addr == ADDR_W'(i))) r_mem[i] <= i_wr_data;
      end
    end
  end

  // Out-of-range addresses match no entry and so read as zero / not busy.
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    w_ra      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_ra = i_rd_addr[k*ADDR_W +: ADDR_W];
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_ra == ADDR_W'(i)) begin
          w_rd_data[k*DATA_W +: DATA_W] = r_mem[i];
          w_rd_busy[k]                  = w_busy_vec[i];
        end
      end
      if (ZERO_REG && (w_ra == '0)) begin
        w_rd_data[k*DATA_W +: DATA_W] = '0;
        w_rd_busy[k]                  = 1'b0;
      end
      if (BYPASS && w_wr_hit && (i_wr_addr == w_ra)) begin
        w_rd_data[k*DATA_W +: DATA_W] = i_wr_data;
        w_rd_busy[k]                  = 1'b0;
      end
    end
  end

  assign o_rd_data  = w_rd_data;
  assign o_rd_busy  = w_rd_busy;
  assign o_busy_vec = w_busy_vec;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_issue_en   (i_issue_en),
    .i_issue_addr (i_issue_addr),
    .o_issue_ok   (o_issue_ok),
    .o_busy_vec   (w_busy_vec),
    .o_busy_cnt   (o_busy_cnt)
  );

endmodule
